// File: rtl/gray_frame_sequencer.sv
// ============================================================================
// Module   : gray_frame_sequencer
// Brief    : One-frame RGB-to-gray sequencer with SOF/EOL/EOF markers and a
//            frame_done pulse. Optional frame counter: GRAY_FRAME_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_frame_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] r_data_in,
  input  logic [DATA_WIDTH-1:0] g_data_in,
  input  logic [DATA_WIDTH-1:0] b_data_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  sof_out,
  output logic                  eol_out,
  output logic                  eof_out,
  output logic                  busy,
  output logic                  frame_done
`ifdef GRAY_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  localparam int SUM_W = DATA_WIDTH + 4;
  localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMG_WIDTH - 1);
  localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMG_HEIGHT - 1);

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  col_q, col_d;
  logic [CNT_WIDTH-1:0]  row_q, row_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  sof_q, sof_d;
  logic                  eol_q, eol_d;
  logic                  eof_q, eof_d;
  logic                  done_q, done_d;

  logic                  in_xfer;
  logic                  out_xfer;
  logic                  col_last;
  logic                  row_last;
  logic [SUM_W-1:0]      r_ext, g_ext, b_ext, gray_sum;

  // Channels are widened by replicating their two MSBs, green weighted by 2.
  assign r_ext    = {2'b00, r_data_in, r_data_in[DATA_WIDTH-1 -: 2]};
  assign g_ext    = {2'b00, g_data_in, g_data_in[DATA_WIDTH-1 -: 2]};
  assign b_ext    = {2'b00, b_data_in, b_data_in[DATA_WIDTH-1 -: 2]};
  assign gray_sum = r_ext + (g_ext << 1) + b_ext;

  assign ready_out = (state_q == ST_ACTIVE) && (!valid_q || ready_in);
  assign in_xfer   = valid_in && ready_out;
  assign out_xfer  = valid_q && ready_in;
  assign col_last  = (col_q == COL_LAST);
  assign row_last  = (row_q == ROW_LAST);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    data_d  = data_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACTIVE;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_ACTIVE: begin
        if (in_xfer && col_last && row_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_xfer) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (in_xfer) begin
      data_d  = DATA_WIDTH'(gray_sum >> 4);
      valid_d = 1'b1;
      sof_d   = (col_q == '0) && (row_q == '0);
      eol_d   = col_last;
      eof_d   = col_last && row_last;
      if (col_last) begin
        col_d = '0;
        row_d = row_q + CNT_WIDTH'(1);
      end else begin
        col_d = col_q + CNT_WIDTH'(1);
      end
    end else if (out_xfer) begin
      valid_d = 1'b0;
    end

    // Abort overrides every other update, including a concurrent handshake.
    if (abort) begin
      state_d = ST_IDLE;
      col_d   = '0;
      row_d   = '0;
      valid_d = 1'b0;
      sof_d   = 1'b0;
      eol_d   = 1'b0;
      eof_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
      done_q  <= done_d;
    end
  end

  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign sof_out    = sof_q;
  assign eol_out    = eol_q;
  assign eof_out    = eof_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = done_q;

`ifdef GRAY_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Updates on the same edge that raises frame_done, so both are seen together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else if (done_d) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_frame_sequencer.sv
// ============================================================================
// Module   : tb_gray_frame_sequencer
// Brief    : Scoreboard bench for gray_frame_sequencer on a 4x2 image.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gray_frame_sequencer;

  localparam int W = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       reset_n, start, abort, valid_in, ready_in;
  logic [7:0] r_data_in, g_data_in, b_data_in;
  logic       ready_out, valid_out, sof_out, eol_out, eof_out, busy, frame_done;
  logic [7:0] data_out;
`ifdef GRAY_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int m_col = 0;
  int m_row = 0;
  logic [10:0] exp_q[$];
  logic [10:0] exp_v;

  always #5 clk = ~clk;

  gray_frame_sequencer #(
    .DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .CNT_WIDTH(11)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .r_data_in(r_data_in), .g_data_in(g_data_in), .b_data_in(b_data_in),
    .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out),
    .valid_out(valid_out), .ready_in(ready_in), .sof_out(sof_out),
    .eol_out(eol_out), .eof_out(eof_out), .busy(busy), .frame_done(frame_done)
`ifdef GRAY_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  function automatic logic [7:0] gray_ref(input int r, input int g, input int b);
    int s;
    s = (r * 4 + r / 64) + 2 * (g * 4 + g / 64) + (b * 4 + b / 64);
    return 8'(s / 16);
  endfunction

  task automatic set_pix(input int k);
    case (k % 4)
      0: begin r_data_in = 8'd255; g_data_in = 8'd255; b_data_in = 8'd255; end
      1: begin r_data_in = 8'd0;   g_data_in = 8'd0;   b_data_in = 8'd0;   end
      2: begin r_data_in = 8'd255; g_data_in = 8'd0;   b_data_in = 8'd0;   end
      default: begin r_data_in = 8'd0; g_data_in = 8'd255; b_data_in = 8'd0; end
    endcase
  endtask

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (reset_n) begin
      if (valid_out && ready_in) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got data=%0d", data_out);
        end else begin
          exp_v = exp_q.pop_front();
          if ({data_out, sof_out, eol_out, eof_out} !== exp_v) begin
            errors++;
            $display("FAIL out_pixel got data=%0d sof/eol/eof=%b%b%b want data=%0d sof/eol/eof=%b",
                     data_out, sof_out, eol_out, eof_out, exp_v[10:3], exp_v[2:0]);
          end
        end
        out_cnt++;
      end
      if (valid_in && ready_out && !abort) begin
        exp_q.push_back({gray_ref(int'(r_data_in), int'(g_data_in), int'(b_data_in)),
                         (m_col == 0 && m_row == 0), (m_col == W - 1),
                         (m_col == W - 1 && m_row == H - 1)});
        if (m_col == W - 1) begin
          m_col = 0;
          m_row++;
        end else begin
          m_col++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    ready_in = 1'b1;
    start    = 1'b1;
    m_col    = 0;
    m_row    = 0;
    step();
    start = 1'b0;
    checks++;
    if ({busy, ready_out} !== 2'b11) begin
      errors++;
      $display("FAIL start_arm got busy=%b ready_out=%b want 1 1", busy, ready_out);
    end
  endtask

  task automatic send_pixels(input int n, input int stall_at, input int start_at);
    int k = 0;
    int cyc = 0;
    logic [10:0] snap = '0;
    logic stall;
    while (k < n && cyc < 200) begin
      set_pix(k);
      valid_in = 1'b1;
      stall    = (stall_at >= 0) && (cyc >= stall_at) && (cyc < stall_at + 3);
      ready_in = !stall;
      start    = (cyc == start_at);
      #1;
      if (stall) begin
        checks++;
        if (ready_out !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready got ready_out=%b want 0", ready_out);
        end
        if (cyc == stall_at) begin
          snap = {data_out, sof_out, eol_out, eof_out};
        end else begin
          checks++;
          if ({data_out, sof_out, eol_out, eof_out} !== snap || valid_out !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold got %h valid=%b want %h valid=1",
                     {data_out, sof_out, eol_out, eof_out}, valid_out, snap);
          end
        end
      end
      if (valid_in && ready_out) k++;
      step();
      cyc++;
    end
    valid_in = 1'b0;
    start    = 1'b0;
    ready_in = 1'b1;
    if (k < n) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got %0d pixels want %0d", k, n);
    end
  endtask

  task automatic finish_frame();
    checks++;
    if ({ready_out, busy} !== 2'b01) begin
      errors++;
      $display("FAIL drain_state got ready_out=%b busy=%b want 0 1", ready_out, busy);
    end
    step();
    checks++;
    if ({frame_done, busy, valid_out} !== 3'b100) begin
      errors++;
      $display("FAIL frame_done got done=%b busy=%b valid=%b want 1 0 0",
               frame_done, busy, valid_out);
    end
    step();
    checks++;
    if (frame_done !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL done_pulse got done=%b pending=%0d want 0 0", frame_done, exp_q.size());
    end
  endtask

  task automatic do_abort();
    abort    = 1'b1;
    ready_in = 1'b0;
    step();
    abort    = 1'b0;
    ready_in = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    valid_in = 1'b1;
    ready_in = 1'b1;
    set_pix(0);
    step();
    step();
    checks++;
    if ({ready_out, valid_out, data_out, sof_out, eol_out, eof_out, busy, frame_done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b data=%0d markers=%b%b%b busy=%b done=%b want all 0",
               ready_out, valid_out, data_out, sof_out, eol_out, eof_out, busy, frame_done);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({ready_out, valid_out, busy} !== 3'b000) begin
        errors++;
        $display("FAIL idle_no_xfer got rdy=%b vld=%b busy=%b want 0 0 0", ready_out, valid_out, busy);
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_full_frame();
    out_cnt = 0;
    do_start();
    send_pixels(8, -1, -1);
    finish_frame();
    checks++;
    if (out_cnt != 8) begin
      errors++;
      $display("FAIL full_count got %0d want 8", out_cnt);
    end
  endtask

  task automatic test_backpressure();
    out_cnt = 0;
    do_start();
    send_pixels(8, 2, -1);
    finish_frame();
    checks++;
    if (out_cnt != 8) begin
      errors++;
      $display("FAIL bp_count got %0d want 8", out_cnt);
    end
  endtask

  task automatic test_abort();
    do_start();
    send_pixels(5, -1, -1);
    do_abort();
    checks++;
    if ({busy, valid_out, sof_out, eol_out, eof_out, frame_done} !== 6'b0) begin
      errors++;
      $display("FAIL abort_state got busy=%b vld=%b markers=%b%b%b done=%b want all 0",
               busy, valid_out, sof_out, eol_out, eof_out, frame_done);
    end
    step();
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done got %b want 0", frame_done);
    end
    out_cnt = 0;
    do_start();
    send_pixels(8, -1, -1);
    finish_frame();
    checks++;
    if (out_cnt != 8) begin
      errors++;
      $display("FAIL post_abort_count got %0d want 8", out_cnt);
    end
  endtask

  task automatic test_start_abort_idle();
    start = 1'b1;
    abort = 1'b1;
    step();
    start    = 1'b0;
    abort    = 1'b0;
    valid_in = 1'b1;
    ready_in = 1'b1;
    #1;
    checks++;
    if ({busy, ready_out} !== 2'b00) begin
      errors++;
      $display("FAIL start_abort got busy=%b ready_out=%b want 0 0", busy, ready_out);
    end
    step();
    checks++;
    if ({busy, ready_out, valid_out} !== 3'b000) begin
      errors++;
      $display("FAIL start_abort_hold got busy=%b rdy=%b vld=%b want 0 0 0", busy, ready_out, valid_out);
    end
    valid_in = 1'b0;
    out_cnt  = 0;
    do_start();
    send_pixels(8, -1, 3);
    finish_frame();
    checks++;
    if (out_cnt != 8) begin
      errors++;
      $display("FAIL start_in_active_count got %0d want 8", out_cnt);
    end
  endtask

`ifdef GRAY_FRAME_CNT_EN
  task automatic test_frame_cnt();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    exp_q.delete();
    checks++;
    if (frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL frame_cnt_reset got %0d want 0", frame_cnt);
    end
    for (int f = 0; f < 3; f++) begin
      do_start();
      send_pixels(8, -1, -1);
      finish_frame();
    end
    do_start();
    send_pixels(3, -1, -1);
    do_abort();
    step();
    checks++;
    if (frame_cnt !== 16'd3) begin
      errors++;
      $display("FAIL frame_cnt got %0d want 3", frame_cnt);
    end
  endtask
`endif

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    valid_in  = 1'b0;
    ready_in  = 1'b0;
    r_data_in = '0;
    g_data_in = '0;
    b_data_in = '0;
    test_reset();
    test_full_frame();
    test_backpressure();
    test_abort();
    test_start_abort_idle();
`ifdef GRAY_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
